// File: rtl/mux_nt1_rr_reg.sv
// Purpose: N-to-1 channel mux with fixed-select or round-robin arbitration and a one-entry output register.
// Latency: 1 cycle from input handshake (in_valid & in_ready) to out_valid.
// Backpressure: in_ready stays low while the output register is full and out_ready is low; full rate when out_ready=1.
module mux_nt1_rr_reg #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int PAD = 2 ** SEL_W;

    // Per-channel data view of the flattened input bus
    logic [WIDTH-1:0]  ch_data [CHANNELS];

    // Valid vector widened to the full select range; channels beyond CHANNELS read as idle
    logic [PAD-1:0]    valid_pad;

    logic [SEL_W-1:0]  rr_ptr;
    logic [SEL_W:0]    rr_cand;
    logic [SEL_W-1:0]  rr_idx;
    logic              rr_found;
    logic              fix_ok;
    logic              reg_free;
    logic              grant;
    logic [SEL_W-1:0]  grant_idx;

    assign valid_pad = PAD'(in_valid);

    // Unpack the flattened input bus into one word per channel
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            ch_data[k] = in_data[k*WIDTH +: WIDTH];
        end
    end

    // Round-robin search: first valid channel after rr_ptr, wrapping modulo CHANNELS
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            rr_cand = {1'b0, rr_ptr} + (SEL_W+1)'(i);
            if (rr_cand >= (SEL_W+1)'(CHANNELS)) begin
                rr_cand = rr_cand - (SEL_W+1)'(CHANNELS);
            end
            if (!rr_found && valid_pad[rr_cand[SEL_W-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand[SEL_W-1:0];
            end
        end
    end

    // Fixed select only grants an in-range channel that is actually presenting data
    assign fix_ok    = ({1'b0, sel} < (SEL_W+1)'(CHANNELS)) && valid_pad[sel];

    // A grant needs a free output slot; reset forces every in_ready low
    assign reg_free  = !out_valid || out_ready;
    assign grant     = !rst && reg_free && (mode ? rr_found : fix_ok);
    assign grant_idx = mode ? rr_idx : sel;
    assign in_ready  = grant ? (CHANNELS'(1) << grant_idx) : '0;

    // Output register: load on grant, empty on consume, hold otherwise; rr_ptr tracks RR grants only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= SEL_W'(CHANNELS - 1);
        end else begin
            if (grant) begin
                out_valid <= 1'b1;
                out_data  <= ch_data[grant_idx];
                out_ch    <= grant_idx;
                if (mode) begin
                    rr_ptr <= grant_idx;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_nt1_rr_reg.sv
// Purpose: directed self-checking bench for mux_nt1_rr_reg (8-channel main instance, 6-channel instance for out-of-range select).
// Latency: outputs sampled on the falling edge, one cycle after the granting rising edge.
// Backpressure: exercised by holding out_ready low on a loaded register.
module tb_mux_nt1_rr_reg;

    logic        clk;
    logic        rst;
    logic [255:0] in_data;
    logic [7:0]  in_valid;
    logic [7:0]  in_ready;
    logic        mode;
    logic [2:0]  sel;
    logic [31:0] out_data;
    logic [2:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    logic [47:0] s_in_data;
    logic [5:0]  s_in_valid;
    logic [5:0]  s_in_ready;
    logic        s_mode;
    logic [2:0]  s_sel;
    logic [7:0]  s_out_data;
    logic [2:0]  s_out_ch;
    logic        s_out_valid;
    logic        s_out_ready;

    int checks;
    int failures;

    mux_nt1_rr_reg #(.WIDTH(32), .CHANNELS(8), .SEL_W(3)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sel(sel), .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_nt1_rr_reg #(.WIDTH(8), .CHANNELS(6), .SEL_W(3)) dut6 (
        .clk(clk), .rst(rst), .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .mode(s_mode), .sel(s_sel), .out_data(s_out_data), .out_ch(s_out_ch),
        .out_valid(s_out_valid), .out_ready(s_out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drain();
        in_valid  = 8'h00;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%h exp=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (out_ch !== 3'd0) begin failures++; $display("FAIL reset_out_ch got=%h exp=0", out_ch); end
        checks++; if (in_ready !== 8'h00) begin failures++; $display("FAIL reset_in_ready got=%h exp=00", in_ready); end
        in_valid = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_release_valid got=%h exp=0", out_valid); end
    endtask

    task automatic test_fixed();
        mode = 1'b0; sel = 3'd5; in_valid = 8'hFF; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 8'h20) begin failures++; $display("FAIL fixed_in_ready0 got=%h exp=20", in_ready); end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fixed_valid c%0d got=%h exp=1", k, out_valid); end
            checks++; if (out_data !== 32'hA000_0005) begin failures++; $display("FAIL fixed_data c%0d got=%h exp=a0000005", k, out_data); end
            checks++; if (out_ch !== 3'd5) begin failures++; $display("FAIL fixed_ch c%0d got=%h exp=5", k, out_ch); end
            checks++; if (in_ready !== 8'h20) begin failures++; $display("FAIL fixed_in_ready c%0d got=%h exp=20", k, in_ready); end
        end
        drain();
    endtask

    task automatic test_rr_all();
        logic [2:0] e_ch;
        logic [7:0] e_rdy;
        mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 8'h01) begin failures++; $display("FAIL rr_all_in_ready0 got=%h exp=01", in_ready); end
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            e_ch  = 3'((k - 1) % 8);
            e_rdy = 8'(1 << (k % 8));
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rr_all_valid c%0d got=%h exp=1", k, out_valid); end
            checks++; if (out_ch !== e_ch) begin failures++; $display("FAIL rr_all_ch c%0d got=%h exp=%h", k, out_ch, e_ch); end
            checks++; if (out_data !== 32'hA000_0000 + 32'(e_ch)) begin failures++; $display("FAIL rr_all_data c%0d got=%h exp=%h", k, out_data, 32'hA000_0000 + 32'(e_ch)); end
            checks++; if (in_ready !== e_rdy) begin failures++; $display("FAIL rr_all_in_ready c%0d got=%h exp=%h", k, in_ready, e_rdy); end
        end
        in_valid = 8'h00;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rr_drain_valid got=%h exp=0", out_valid); end
        checks++; if (out_ch !== 3'd1) begin failures++; $display("FAIL rr_drain_hold_ch got=%h exp=1", out_ch); end
        checks++; if (out_data !== 32'hA000_0001) begin failures++; $display("FAIL rr_drain_hold_data got=%h exp=a0000001", out_data); end
    endtask

    task automatic test_rr_sparse();
        logic [2:0] e_ch;
        logic [7:0] e_rdy;
        // Pointer sits at 1 from the previous test, so the search starts at 2 and finds 7 first
        mode = 1'b1; in_valid = 8'h82; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 8'h80) begin failures++; $display("FAIL sparse_in_ready0 got=%h exp=80", in_ready); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            e_ch  = (k % 2 == 1) ? 3'd7 : 3'd1;
            e_rdy = (k % 2 == 1) ? 8'h02 : 8'h80;
            checks++; if (out_ch !== e_ch) begin failures++; $display("FAIL sparse_ch c%0d got=%h exp=%h", k, out_ch, e_ch); end
            checks++; if (in_ready !== e_rdy) begin failures++; $display("FAIL sparse_in_ready c%0d got=%h exp=%h", k, in_ready, e_rdy); end
        end
        in_valid = 8'h02;
        #1;
        checks++; if (in_ready !== 8'h02) begin failures++; $display("FAIL sparse_drop7_in_ready got=%h exp=02", in_ready); end
        for (int k = 5; k <= 7; k++) begin
            @(negedge clk);
            checks++; if (out_ch !== 3'd1) begin failures++; $display("FAIL sparse_only1_ch c%0d got=%h exp=1", k, out_ch); end
            checks++; if (out_data !== 32'hA000_0001) begin failures++; $display("FAIL sparse_only1_data c%0d got=%h exp=a0000001", k, out_data); end
            checks++; if (in_ready !== 8'h02) begin failures++; $display("FAIL sparse_only1_in_ready c%0d got=%h exp=02", k, in_ready); end
        end
        drain();
    endtask

    task automatic test_backpressure();
        // Pointer at 1: first grant is channel 2
        mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 8'h04) begin failures++; $display("FAIL bp_in_ready0 got=%h exp=04", in_ready); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid c%0d got=%h exp=1", k, out_valid); end
            checks++; if (out_ch !== 3'd2) begin failures++; $display("FAIL bp_ch c%0d got=%h exp=2", k, out_ch); end
            checks++; if (out_data !== 32'hA000_0002) begin failures++; $display("FAIL bp_data c%0d got=%h exp=a0000002", k, out_data); end
            checks++; if (in_ready !== 8'h00) begin failures++; $display("FAIL bp_in_ready c%0d got=%h exp=00", k, in_ready); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 8'h08) begin failures++; $display("FAIL bp_release_in_ready got=%h exp=08", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_nobubble_valid got=%h exp=1", out_valid); end
        checks++; if (out_ch !== 3'd3) begin failures++; $display("FAIL bp_nobubble_ch got=%h exp=3", out_ch); end
        in_valid = 8'h00;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty_valid got=%h exp=0", out_valid); end
    endtask

    task automatic test_mode_switch_and_reset();
        // Pointer at 3: round-robin grant goes to channel 4, then stalls
        mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 8'h10) begin failures++; $display("FAIL ms_in_ready0 got=%h exp=10", in_ready); end
        @(negedge clk);
        checks++; if (out_ch !== 3'd4) begin failures++; $display("FAIL ms_load_ch got=%h exp=4", out_ch); end
        mode = 1'b0; sel = 3'd6;
        #1;
        checks++; if (in_ready !== 8'h00) begin failures++; $display("FAIL ms_stall_in_ready got=%h exp=00", in_ready); end
        @(negedge clk);
        checks++; if (out_ch !== 3'd4) begin failures++; $display("FAIL ms_held_ch got=%h exp=4", out_ch); end
        checks++; if (out_data !== 32'hA000_0004) begin failures++; $display("FAIL ms_held_data got=%h exp=a0000004", out_data); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 8'h40) begin failures++; $display("FAIL ms_fixed_in_ready got=%h exp=40", in_ready); end
        @(negedge clk);
        checks++; if (out_ch !== 3'd6) begin failures++; $display("FAIL ms_fixed_ch got=%h exp=6", out_ch); end
        checks++; if (out_data !== 32'hA000_0006) begin failures++; $display("FAIL ms_fixed_data got=%h exp=a0000006", out_data); end
        // Stall a held word, then reset between edges
        out_ready = 1'b0; mode = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mrst_valid got=%h exp=0", out_valid); end
        checks++; if (out_ch !== 3'd0) begin failures++; $display("FAIL mrst_ch got=%h exp=0", out_ch); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL mrst_data got=%h exp=0", out_data); end
        checks++; if (in_ready !== 8'h00) begin failures++; $display("FAIL mrst_in_ready got=%h exp=00", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 8'h01) begin failures++; $display("FAIL mrst_restart_in_ready got=%h exp=01", in_ready); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mrst_restart_valid got=%h exp=1", out_valid); end
        checks++; if (out_ch !== 3'd0) begin failures++; $display("FAIL mrst_restart_ch got=%h exp=0", out_ch); end
        drain();
    endtask

    task automatic test_sel_range();
        s_mode = 1'b0; s_sel = 3'd7; s_in_valid = 6'h3F; s_out_ready = 1'b1;
        #1;
        checks++; if (s_in_ready !== 6'h00) begin failures++; $display("FAIL sel_oor_in_ready got=%h exp=00", s_in_ready); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (s_out_valid !== 1'b0) begin failures++; $display("FAIL sel_oor_valid got=%h exp=0", s_out_valid); end
        s_sel = 3'd5;
        #1;
        checks++; if (s_in_ready !== 6'h20) begin failures++; $display("FAIL sel_top_in_ready got=%h exp=20", s_in_ready); end
        @(negedge clk);
        checks++; if (s_out_ch !== 3'd5) begin failures++; $display("FAIL sel_top_ch got=%h exp=5", s_out_ch); end
        checks++; if (s_out_data !== 8'hB5) begin failures++; $display("FAIL sel_top_data got=%h exp=b5", s_out_data); end
        // Round-robin on a 6-channel instance starts at 0 and wraps 5 -> 0
        s_mode = 1'b1;
        #1;
        checks++; if (s_in_ready !== 6'h01) begin failures++; $display("FAIL sel6_rr_in_ready got=%h exp=01", s_in_ready); end
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checks++; if (s_out_ch !== 3'((k - 1) % 6)) begin failures++; $display("FAIL sel6_rr_ch c%0d got=%h exp=%h", k, s_out_ch, 3'((k - 1) % 6)); end
        end
        s_in_valid = 6'h00;
        @(negedge clk);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b0; mode = 1'b0; sel = 3'd0; in_valid = 8'h00; out_ready = 1'b0;
        s_mode = 1'b0; s_sel = 3'd0; s_in_valid = 6'h00; s_out_ready = 1'b0;
        for (int k = 0; k < 8; k++) in_data[k*32 +: 32] = 32'hA000_0000 + 32'(k);
        for (int k = 0; k < 6; k++) s_in_data[k*8 +: 8] = 8'hB0 + 8'(k);

        test_reset();
        test_fixed();
        test_rr_all();
        test_rr_sparse();
        test_backpressure();
        test_mode_switch_and_reset();
        test_sel_range();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_nt1_rr_reg.md
Name: mux_nt1_rr_reg

Overview:
Parametrised, registered N-to-1 channel multiplexer. It is the successor to the combinational 8:1 32-bit select mux used in the ALU datapath. It adds valid/ready handshakes per input channel and on the output, a one-entry output register, and two selection modes: fixed (external select) and round-robin (fair arbitration among valid channels). It sits between multiple producers (ALU/result sources, test stimulus) and a single consumer stage.

Parameters:
WIDTH, 32, data bits per channel
CHANNELS, 8, number of input channels (2..16)
SEL_W, 3, select/channel-index width; must equal ceil(log2(CHANNELS))

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  CHANNELS*WIDTH  flattened inputs; channel k occupies bits [k*WIDTH +: WIDTH]
in_valid  input  CHANNELS  per-channel data valid
in_ready  output  CHANNELS  per-channel accept (combinational)
mode  input  1  0 = fixed select, 1 = round-robin
sel  input  SEL_W  channel index used in fixed mode
out_data  output  WIDTH  registered selected data
out_ch  output  SEL_W  registered index of channel that supplied out_data
out_valid  output  1  output register holds data
out_ready  input  1  consumer accepts out_data this cycle

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_ch=0, rr_ptr=CHANNELS-1, so the first round-robin search starts at channel 0. All in_ready=0 while rst=1.
- Output register is free when (!out_valid | out_ready). A grant occurs only when the register is free.
- Fixed mode: grant channel g = sel if in_valid[sel]=1 and sel<CHANNELS. Otherwise there is no grant. Valid on other channels is ignored.
- Round-robin mode: search rr_ptr+1, rr_ptr+2, ... with wrap modulo CHANNELS. The first channel with in_valid=1 is granted. rr_ptr updates to g only on a round-robin grant. Fixed-mode grants do not move rr_ptr.
- in_ready: one-hot on g when a grant occurs, all zero otherwise. in_ready is never asserted on a channel with in_valid=0.
- Input transfer: on a clock edge with a grant, out_data<=in_data[g], out_ch<=g, out_valid<=1. Latency is 1 cycle from input handshake to out_valid.
- Output transfer: out_valid & out_ready. With no simultaneous grant, out_valid<=0 and out_data/out_ch hold their last values.
- Simultaneous output consume and new grant in the same cycle: the register reloads, out_valid stays 1. This gives full throughput of 1 word/cycle.
- out_valid=1 with out_ready=0: out_data/out_ch are stable and in_ready stays all zero.
- mode or sel change while out_valid=1: the held output is unaffected. The new setting applies to the next grant only.
- sel >= CHANNELS (non-power-of-two CHANNELS): there is no grant and the block does not hang.
- Reset asserted mid-transfer: all state returns to reset values immediately. Any in-flight output word is discarded.
- No combinational path from in_data to out_data. There is a combinational path from in_valid/mode/sel/out_ready to in_ready.

Test Plan:
- Reset: assert rst asynchronously between clock edges -> out_valid=0, out_data=0, out_ch=0, in_ready=0 with no clock edge required.
- Fixed mode, mode=0, sel=5, in_valid=8'hFF, channel k data = 32'hA0000000+k, out_ready=1 -> in_ready=8'h20 each cycle; out_data=32'hA0000005, out_ch=5 from cycle 1.
- Round-robin, all valid, out_ready=1 -> out_ch sequence 0,1,2,...,7,0,1 on consecutive cycles; one word/cycle; in_ready one-hot matching.
- Round-robin sparse wrap: in_valid=8'b1000_0010 held -> out_ch alternates 1,7,1,7. Then drop in_valid[7] -> only 1 repeats.
- Backpressure: out_ready=0 for 4 cycles after the first load -> out_data/out_ch stable, in_ready=0. Raise out_ready -> the next grant lands the same cycle with no bubble.
- Mid-operation: toggle mode 1->0 while out_valid=1 and stalled -> held word unchanged; the next grant follows sel. Pulse rst while out_valid=1 -> out_valid=0 and the subsequent RR search restarts at channel 0.
